// File: rtl/demux_1_to_32_collector.sv
// Bit-serial to 32-bit parallel collector.
// Each accepted serial bit is steered onto output_lines[index] and held in a register bank.
// Once every line of the current word has been written, the word is offered downstream
// with a valid/ready handshake.
module demux_1_to_32_collector #(
    parameter int unsigned N_LINES  = 32,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned AUTO_INC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               input_line,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   selector_bits,
    output logic [N_LINES-1:0] output_lines,
    output logic [N_LINES-1:0] filled_mask,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_LINES-1:0] lines_q, lines_d;
    logic [N_LINES-1:0] mask_q,  mask_d;
    logic [SEL_W-1:0]   idx_q,   idx_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   wr_idx;

    // Next-state and output logic; clear outranks both handshakes.
    always_comb begin
        state_d     = state_q;
        lines_d     = lines_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        wr_idx      = (AUTO_INC != 0) ? idx_q : selector_bits;

        if (clear) begin
            state_d     = COLLECT;
            lines_d     = '0;
            mask_d      = '0;
            idx_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (in_valid && in_ready_q) begin
                        lines_d[wr_idx] = input_line;
                        mask_d[wr_idx]  = 1'b1;
                        if (AUTO_INC != 0) begin
                            idx_d = idx_q + SEL_W'(1);
                        end
                        // Word becomes complete on the edge that fills its last line.
                        if (&mask_d) begin
                            state_d     = FULL;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Word is frozen until the consumer takes it; one bubble per word.
                    if (out_ready) begin
                        state_d     = COLLECT;
                        lines_d     = '0;
                        mask_d      = '0;
                        idx_d       = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = COLLECT;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            lines_q     <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lines_q     <= lines_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign output_lines = lines_q;
    assign filled_mask  = mask_q;

endmodule
